enc_event_fifo: RTL

ENC_EVENT_FIFO -- requirements
Module: enc_event_fifo

---
 rtl/enc_event_fifo.sv | 68 ++++++
 1 files changed

// File: rtl/enc_event_fifo.sv
// enc_event_fifo: turns a priority encoder's held output into single events and queues them first-in first-out.
// Define ENC_FIFO_DROP_CNT_EN to count events lost to overflow (drop_cnt, saturating); otherwise drop_cnt is 0.
module enc_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             in_idx,
  input  logic                   in_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_idx,
  output logic                   out_valid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          last_valid_q;
  logic [1:0]    last_idx_q;
  logic [1:0]    mem_q [DEPTH];
  logic          evt, pop, push;
  always_comb begin
    evt      = in_valid && (!last_valid_q || in_idx != last_idx_q);
    pop      = out_valid && out_ready;
    push     = evt && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
  end
  assign empty     = count_q == '0;
  assign full      = count_q == FULL_CNT;
  assign out_valid = !empty;
  assign count     = count_q;
  // Storage is never cleared, so mask the head while empty to keep out_idx at 0
  assign out_idx   = empty ? 2'd0 : mem_q[rd_ptr_q];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_valid_q <= 1'b0;
      last_idx_q   <= 2'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_valid_q <= in_valid;
      last_idx_q   <= in_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_idx;
  end
`ifdef ENC_FIFO_DROP_CNT_EN
  logic [7:0] drop_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= 8'd0;
    else if (evt && !push && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'd0;
`endif
endmodule
